// File: rtl/sr_ff_pkg.sv
// Shared types and the single-bit next-state rule for the SR flip-flop bank.
package sr_ff_pkg;

  typedef logic [1:0] sr_mode_t;

  localparam sr_mode_t MODE_HOLD   = 2'd0;
  localparam sr_mode_t MODE_SET    = 2'd1;
  localparam sr_mode_t MODE_RESET  = 2'd2;
  localparam sr_mode_t MODE_TOGGLE = 2'd3;

  // S=R=1 is resolved by mode; all other S/R pairs behave as a classic SR flip-flop.
  function automatic logic sr_next(logic q, logic s, logic r, sr_mode_t mode);
    logic nq;
    nq = q;
    unique case ({s, r})
      2'b00: nq = q;
      2'b10: nq = 1'b1;
      2'b01: nq = 1'b0;
      2'b11: begin
        unique case (mode)
          MODE_HOLD:   nq = q;
          MODE_SET:    nq = 1'b1;
          MODE_RESET:  nq = 1'b0;
          MODE_TOGGLE: nq = ~q;
        endcase
      end
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// One channel of the SR flip-flop bank: registered q/qm pair plus a combinational
// conflict event for the flag logic in the top level.
module sr_ff_cell
  import sr_ff_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     act,
  input  logic     s,
  input  logic     r,
  input  sr_mode_t mode,
  input  logic     rst_val,
  output logic     q,
  output logic     qm,
  output logic     conflict_evt
);

  logic q_d;

  always_comb begin
    q_d = act ? sr_next(q, s, r, mode) : q;
  end

  // qm is its own register so it can never momentarily equal q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q  <= rst_val;
      qm <= ~rst_val;
    end else begin
      q  <= q_d;
      qm <= ~q_d;
    end
  end

  assign conflict_evt = act & s & r;

endmodule

// File: rtl/sr_ff_bank.sv
// N-channel clocked SR flip-flop bank with sticky conflict flags.
// Define SR_FF_BANK_CONFLICT_CNT_EN to build the saturating conflict-cycle counter.
module sr_ff_bank
  import sr_ff_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter logic [N-1:0] RESET_VAL = '0,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     ch_en,
  input  logic [N-1:0]     S,
  input  logic [N-1:0]     R,
  input  sr_mode_t         mode,
  input  logic             conflict_clr,
  output logic [N-1:0]     Q,
  output logic [N-1:0]     Qm,
  output logic [N-1:0]     conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic [N-1:0] evt;

  for (genvar i = 0; i < N; i++) begin : g_cell
    sr_ff_cell u_cell (
      .clk          (clk),
      .rst          (rst),
      .act          (en & ch_en[i]),
      .s            (S[i]),
      .r            (R[i]),
      .mode         (mode),
      .rst_val      (RESET_VAL[i]),
      .q            (Q[i]),
      .qm           (Qm[i]),
      .conflict_evt (evt[i])
    );
  end

  // A new event on the clearing edge survives the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict <= '0;
    end else if (conflict_clr) begin
      conflict <= evt;
    end else begin
      conflict <= conflict | evt;
    end
  end

`ifdef SR_FF_BANK_CONFLICT_CNT_EN
  logic any_evt;
  assign any_evt = |evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (conflict_clr) begin
      conflict_cnt <= CNT_W'(any_evt);
    end else if (any_evt && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed self-checking bench for sr_ff_bank (N=4, CNT_W=4, RESET_VAL=4'b0101).
module tb_sr_ff_bank;
  import sr_ff_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] ch_en;
  logic [3:0] S;
  logic [3:0] R;
  sr_mode_t   mode;
  logic       conflict_clr;
  logic [3:0] Q;
  logic [3:0] Qm;
  logic [3:0] conflict;
  logic [3:0] conflict_cnt;

  int vectors = 0;
  int miscompares = 0;

  sr_ff_bank #(
    .N         (4),
    .RESET_VAL (4'b0101),
    .CNT_W     (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .ch_en        (ch_en),
    .S            (S),
    .R            (R),
    .mode         (mode),
    .conflict_clr (conflict_clr),
    .Q            (Q),
    .Qm           (Qm),
    .conflict     (conflict),
    .conflict_cnt (conflict_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counter expectations collapse to zero when the counter is compiled out.
  function automatic logic [3:0] ecnt(int v);
`ifdef SR_FF_BANK_CONFLICT_CNT_EN
    return 4'(v);
`else
    return 4'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eq, input logic [3:0] ec,
                         input logic [3:0] ecn);
    chk({tag, ".Q"}, Q, eq);
    chk({tag, ".Qm"}, Qm, ~eq);
    chk({tag, ".conflict"}, conflict, ec);
    chk({tag, ".cnt"}, conflict_cnt, ecn);
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; ch_en = 4'b0000; S = 4'b0000; R = 4'b0000;
    mode = MODE_HOLD; conflict_clr = 1'b0;
    #1 rst = 1'b1;
    #1 chk_all("reset_init", 4'b0101, 4'b0000, ecnt(0));
    #6 rst = 1'b0;

    // Build up state and a conflict, then reset asynchronously mid-cycle.
    en = 1'b1; ch_en = 4'b1111; S = 4'b1111; R = 4'b0001; mode = MODE_HOLD;
    step();
    chk_all("pre_reset", 4'b1111, 4'b0001, ecnt(1));
    #2 rst = 1'b1;
    #1 chk_all("async_reset", 4'b0101, 4'b0000, ecnt(0));
    #1 rst = 1'b0;

    // Basic SR and hold.
    S = 4'b0011; R = 4'b1100;
    step();
    chk_all("basic_sr", 4'b0011, 4'b0000, ecnt(0));
    S = 4'b0000; R = 4'b0000;
    step();
    chk("hold1.Q", Q, 4'b0011);
    step();
    step();
    chk_all("hold3", 4'b0011, 4'b0000, ecnt(0));

    // S=R=1 under each mode.
    S = 4'b1111; R = 4'b1111;
    mode = MODE_HOLD;   step(); chk_all("mode_hold", 4'b0011, 4'b1111, ecnt(1));
    mode = MODE_SET;    step(); chk_all("mode_set", 4'b1111, 4'b1111, ecnt(2));
    mode = MODE_RESET;  step(); chk_all("mode_reset", 4'b0000, 4'b1111, ecnt(3));
    mode = MODE_TOGGLE; step(); chk_all("mode_tog1", 4'b1111, 4'b1111, ecnt(4));
    step();                     chk_all("mode_tog2", 4'b0000, 4'b1111, ecnt(5));

    // Clear alone.
    S = 4'b0000; R = 4'b0000; conflict_clr = 1'b1;
    step();
    conflict_clr = 1'b0;
    chk_all("clr_alone", 4'b0000, 4'b0000, ecnt(0));

    // Global enable low freezes everything.
    en = 1'b0; S = 4'b1111; R = 4'b1111; mode = MODE_SET;
    step();
    chk_all("en_off", 4'b0000, 4'b0000, ecnt(0));

    // Only channel 0 enabled.
    en = 1'b1; ch_en = 4'b0001; S = 4'b1111; R = 4'b0001; mode = MODE_TOGGLE;
    step();
    chk_all("ch0_only", 4'b0001, 4'b0001, ecnt(1));

    // Saturation: 13 more conflict cycles -> 14, then 7 more -> 15.
    ch_en = 4'b1111; S = 4'b1111; R = 4'b1111; mode = MODE_HOLD;
    for (int i = 0; i < 13; i++) step();
    chk_all("cnt_14", 4'b0001, 4'b1111, ecnt(14));
    for (int i = 0; i < 7; i++) step();
    chk_all("cnt_sat", 4'b0001, 4'b1111, ecnt(15));

    // Clear with simultaneous conflict, then clear alone.
    conflict_clr = 1'b1;
    step();
    chk_all("clr_with_evt", 4'b0001, 4'b1111, ecnt(1));
    S = 4'b0000; R = 4'b0000;
    step();
    conflict_clr = 1'b0;
    chk_all("clr_after", 4'b0001, 4'b0000, ecnt(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
